// File: rtl/ssd1306_pkg.sv
// Purpose : shared definitions for the SSD1306 SPI arbiter: FSM encoding, lock-owner codes, D/C levels.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package ssd1306_pkg;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_GAP    = 3'd4
  } arb_state_t;

  // Burst-lock owner codes, also exported on the owner port.
  typedef logic [1:0] owner_t;
  localparam owner_t OWN_NONE = 2'b00;
  localparam owner_t OWN_CMD  = 2'b01;
  localparam owner_t OWN_PIX  = 2'b10;

  // SSD1306 D/C line levels.
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // Width of the shared gap/timeout down-counter (timeout needs 16 bits, gap fits in the low 8).
  localparam int TMR_W = 16;

endpackage

// File: rtl/ssd1306_spi_arbiter_if.sv
// Purpose : byte-requester and spi_master signal bundle for the SSD1306 arbiter.
// Latency : n/a (wires only).
// Backpr. : cmd/pix use valid/ready; the spi side is strobe (spi_wr) + completion pulse.
// Modports: slave  = arbiter side (accepts requester bytes, drives spi_master/D/C).
//           master = environment side (requesters, spi_master, OLED pin).
interface ssd1306_spi_arbiter_if #(
  parameter int WORD_LEN = 8
);
  logic                cmd_valid;
  logic [WORD_LEN-1:0] cmd_byte;
  logic                cmd_last;
  logic                cmd_ready;

  logic                pix_valid;
  logic [WORD_LEN-1:0] pix_byte;
  logic                pix_last;
  logic                pix_ready;

  logic [WORD_LEN-1:0] spi_data_in;
  logic                spi_wr;
  logic                spi_charreceived;
  logic                oled_dc;

  modport slave (
    input  cmd_valid, cmd_byte, cmd_last,
    output cmd_ready,
    input  pix_valid, pix_byte, pix_last,
    output pix_ready,
    output spi_data_in, spi_wr, oled_dc,
    input  spi_charreceived
  );

  modport master (
    output cmd_valid, cmd_byte, cmd_last,
    input  cmd_ready,
    output pix_valid, pix_byte, pix_last,
    input  pix_ready,
    input  spi_data_in, spi_wr, oled_dc,
    output spi_charreceived
  );

endinterface

// File: rtl/ssd1306_arb_timer.sv
// Purpose : loadable down-counter with terminal-count flag, shared by WAIT timeout and GAP spacing.
// Latency : load takes effect next clock; tc is combinational from the count.
// Backpr. : none; dec is ignored once the count reaches zero (saturates).
// Ports   : clk, rst (async, active-high); load/load_val reload; dec steps down; tc = count is zero.
module ssd1306_arb_timer
  import ssd1306_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !tc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ssd1306_spi_arbiter.sv
// Purpose : shares one spi_master between the SSD1306 command stream (DC=0) and pixel stream (DC=1).
// Latency : accept -> spi_wr strobe is 2 clocks; byte period = 3 + SPI time + GAP_CYCLES.
// Backpr. : x_ready pulses one cycle per byte, only in IDLE; a locked burst stalls the other port.
// Ports   : clk, rst (async, active-high); bus (slave modport: cmd/pix valid-ready byte ports,
//           spi_data_in/spi_wr/spi_charreceived to spi_master, oled_dc); clr_err clears timeout_err;
//           busy = not IDLE; owner = burst-lock owner; timeout_err = sticky stall flag.
// Option  : define SSD1306_ARB_STATS_EN to add cmd_count/pix_count accepted-byte counters.
module ssd1306_spi_arbiter
  import ssd1306_pkg::*;
#(
  parameter int WORD_LEN       = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  ssd1306_spi_arbiter_if.slave bus,
  input  logic                 clr_err,
  output logic                 busy,
  output owner_t               owner,
  output logic                 timeout_err
`ifdef SSD1306_ARB_STATS_EN
  ,
  output logic [15:0]          cmd_count,
  output logic [15:0]          pix_count
`endif
);

  // WAIT gives up on the TIMEOUT_CYCLES-th cycle without a completion pulse.
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;

  arb_state_t          state_q, state_d;
  logic [WORD_LEN-1:0] byte_q, byte_d;
  logic                dc_q, dc_d;
  owner_t              owner_q, owner_d;
  logic                err_q, err_d;

  logic                win_cmd, win_pix, acc_last;
  logic                tmr_load, tmr_dec, tmr_tc;
  logic [TMR_W-1:0]    tmr_val;

  // Winner selection. A held lock makes only its owner eligible; otherwise cmd has priority.
  // Gated by rst so nothing is acknowledged while the state is being held in reset.
  always_comb begin
    win_cmd = 1'b0;
    win_pix = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (owner_q != OWN_PIX && bus.cmd_valid) begin
        win_cmd = 1'b1;
      end else if (owner_q != OWN_CMD && bus.pix_valid) begin
        win_pix = 1'b1;
      end
    end
  end

  assign bus.cmd_ready = win_cmd;
  assign bus.pix_ready = win_pix;

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    dc_d     = dc_q;
    owner_d  = owner_q;
    err_d    = clr_err ? 1'b0 : err_q;
    acc_last = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TO_LOAD;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_cmd || win_pix) begin
          byte_d   = win_cmd ? bus.cmd_byte : bus.pix_byte;
          dc_d     = win_cmd ? DC_CMD : DC_DATA;
          acc_last = win_cmd ? bus.cmd_last : bus.pix_last;
          // A single-byte burst (last on the first byte) never takes the lock.
          owner_d  = acc_last ? OWN_NONE : (win_cmd ? OWN_CMD : OWN_PIX);
          state_d  = ST_SETUP;
        end
      end

      // One clock of D/C and data setup ahead of the write strobe.
      ST_SETUP: state_d = ST_SETUP == state_q ? ST_STROBE : state_q;

      ST_STROBE: begin
        // Restart the timeout window for this byte.
        tmr_load = 1'b1;
        tmr_val  = TO_LOAD;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.spi_charreceived || tmr_tc) begin
          // Completion on the final timeout cycle still counts as success.
          if (!bus.spi_charreceived) begin
            err_d   = 1'b1;
            owner_d = OWN_NONE;
          end
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = ST_GAP;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_GAP: begin
        if (tmr_tc) begin
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      dc_q    <= DC_CMD;
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      dc_q    <= dc_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  ssd1306_arb_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .tc       (tmr_tc)
  );

  // spi_wr decodes straight from the state flop, so an async reset drops it immediately.
  assign bus.spi_wr      = (state_q == ST_STROBE);
  assign bus.spi_data_in = byte_q;
  assign bus.oled_dc     = dc_q;
  assign busy            = (state_q != ST_IDLE);
  assign owner           = owner_q;
  assign timeout_err     = err_q;

`ifdef SSD1306_ARB_STATS_EN
  logic [15:0] cmd_cnt_q, cmd_cnt_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;

  // Counters wrap naturally at 16 bits; clr_err takes precedence over a same-cycle accept.
  always_comb begin
    cmd_cnt_d = cmd_cnt_q;
    pix_cnt_d = pix_cnt_q;
    if (clr_err) begin
      cmd_cnt_d = '0;
      pix_cnt_d = '0;
    end else begin
      if (win_cmd) cmd_cnt_d = cmd_cnt_q + 16'd1;
      if (win_pix) pix_cnt_d = pix_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      cmd_cnt_q <= cmd_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign cmd_count = cmd_cnt_q;
  assign pix_count = pix_cnt_q;
`endif

endmodule

// File: doc/ssd1306_spi_arbiter.md
Name: ssd1306_spi_arbiter

Overview:
- Shares the single spi_master instance that drives the SSD1306 between two byte requesters: the command stream (init/config sequencer, DC=0) and the pixel stream (framebuffer reader, DC=1).
- Owns oled_dc and sequences spi_master wr/data_in/charreceived so DC is stable for each byte.
- Supports burst locking, so a multi-byte command or pixel run is never interleaved.
- Detects a stalled SPI transfer with a timeout.

Parameters:
- WORD_LEN, 8, byte width on both requester ports and to spi_master.
- GAP_CYCLES, 2, idle clocks between end of one byte and the next grant (range 0..255).
- TIMEOUT_CYCLES, 4096, max clocks waiting for spi_charreceived before abort (range 1..65535).

Ports:
- clk  in  1  block clock; same clock as spi_master.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command byte offered.
- cmd_byte  in  WORD_LEN  command byte.
- cmd_last  in  1  last byte of command burst; releases lock.
- cmd_ready  out  1  command byte accepted this cycle.
- pix_valid  in  1  pixel byte offered.
- pix_byte  in  WORD_LEN  pixel byte.
- pix_last  in  1  last byte of pixel burst.
- pix_ready  out  1  pixel byte accepted this cycle.
- spi_data_in  out  WORD_LEN  byte to spi_master data_in.
- spi_wr  out  1  one-cycle write strobe to spi_master.
- spi_charreceived  in  1  spi_master transfer-complete pulse.
- oled_dc  out  1  SSD1306 D/C line: 0 = command, 1 = data.
- busy  out  1  high in any state other than IDLE.
- owner  out  2  current lock owner: 00 none, 01 cmd, 10 pix.
- timeout_err  out  1  sticky timeout flag.
- clr_err  in  1  synchronous clear of timeout_err.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state IDLE, all outputs 0, owner=00, lock cleared, counters 0. Reset mid-transfer forces spi_wr=0 immediately; the in-flight byte is abandoned.
- FSM states: IDLE, SETUP, STROBE, WAIT, GAP.
- IDLE: pick winner.
  - If owner=01, only cmd is eligible; if owner=10, only pix is eligible.
  - If owner=00, cmd has fixed priority over pix.
  - x_ready is combinational: state==IDLE && winner==x && x_valid. It is high for exactly one cycle per byte, and only one ready is ever high.
  - On accept: register byte, dc (cmd→0, pix→1) and last.
  - owner <= last ? 00 : winner. A burst of length 1 never locks.
  - Next state SETUP.
- SETUP: drive oled_dc and spi_data_in from the registers, spi_wr=0. Lasts 1 cycle, giving DC one clock of setup before the strobe.
- STROBE: spi_wr=1 for exactly 1 cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - oled_dc and spi_data_in are held; spi_wr=0; timeout counter increments.
  - On spi_charreceived, go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without charreceived: set timeout_err, owner <= 00, go to GAP.
  - If charreceived and timeout coincide, charreceived wins: no error.
- GAP: counts GAP_CYCLES clocks, then IDLE. With GAP_CYCLES=0, GAP lasts 0 cycles (WAIT→IDLE directly). oled_dc holds its last value through GAP and IDLE.
- Latency: accept-to-strobe = 2 cycles (accept cycle, SETUP, strobe). Minimum per-byte period = 3 + SPI time + GAP_CYCLES.
- Locked requester drops valid mid-burst: the arbiter waits in IDLE indefinitely. The other port is not served until the lock is released; the lock is released only by a last byte or by a timeout.
- clr_err:
  - Clears timeout_err next cycle.
  - If set and clear happen in the same cycle, set wins.
- Counter widths: gap counter is 8 bits; timeout counter is 16 bits.

Optional Feature:
- Macro: SSD1306_ARB_STATS_EN.
- When defined, adds outputs cmd_count[15:0] and pix_count[15:0]. Each increments on every accepted byte for its port, wraps 0xFFFF→0, resets to 0, and is also cleared by clr_err.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package ssd1306_pkg holds:
  - FSM state encoding.
  - owner codes OWN_NONE=2'b00, OWN_CMD=2'b01, OWN_PIX=2'b10.
  - DC_CMD=0, DC_DATA=1.
- One natural sub-module: ssd1306_arb_timer, a loadable down-counter shared by GAP and WAIT timing, with a terminal-count flag.

Test Plan:
- Single command: cmd_valid=1, cmd_byte=0xAF, cmd_last=1 → cmd_ready for 1 cycle; oled_dc=0 one cycle before spi_wr; spi_data_in=0xAF; owner stays 00.
- Priority: cmd and pix both valid in IDLE (cmd 0xA6, pix 0x55) → cmd served first with dc=0, then pix with dc=1; never both ready.
- Burst lock: pix burst 0x01,0x02,0x03 (last on 0x03) while cmd_valid is asserted after byte 1 → all three pix bytes are sent before cmd; owner=10 until 0x03 is accepted.
- Timeout: spi_charreceived held 0 with TIMEOUT_CYCLES=16 → timeout_err=1 at WAIT cycle 16; owner=00; next byte proceeds; clr_err pulse → flag 0.
- GAP_CYCLES=0 vs 2: back-to-back cmd bytes → spi_wr pulses separated by SPI time+3 vs +5 cycles.
- Reset during WAIT: assert rst asynchronously → spi_wr, oled_dc, busy and owner are 0 before the next clk edge; after release, IDLE accepts a new byte.
